// File: rtl/dds_pkg.sv
// dds_pkg
// Shared definitions for the DDS sweep controller: default word widths of the
// target dds and the controller state encoding.
package dds_pkg;

   localparam int DDS_FREQ_WIDTH  = 48;
   localparam int DDS_PHASE_WIDTH = 16;

   typedef enum logic [2:0] {
      ST_IDLE        = 3'd0,
      ST_SHIFT_PHASE = 3'd1,
      ST_SHIFT_FREQ  = 3'd2,
      ST_LATCH       = 3'd3,
      ST_DWELL       = 3'd4,
      ST_FINISH      = 3'd5
   } state_e;

endpackage

// File: rtl/dds_spi_shifter.sv
// dds_spi_shifter
// Generic MSB-first serializer. A word is loaded left-aligned in data together
// with its bit count; each bit is presented with spi_clk low for CLK_DIV
// cycles and then high for CLK_DIV cycles.
// Ports:
//   sys_clk, rst   clock, asynchronous active-high reset
//   load           start shifting data (ignored while active)
//   width          number of bits to shift, taken from the top of data
//   data           word to shift, MSB at data[MAX_WIDTH-1]
//   spi_clk        serial clock, low while idle
//   spi_data       serial data, low while idle
//   active         high for the whole 2*CLK_DIV*width cycles of a word
//   bit_done       high in the final cycle of each bit's high phase
//   last_bit       high while the final bit of the word is presented
module dds_spi_shifter
   import dds_pkg::*;
#(
   parameter int MAX_WIDTH = DDS_FREQ_WIDTH,
   parameter int CLK_DIV   = 2,
   parameter int CNT_W     = $clog2(MAX_WIDTH + 1)
) (
   input  logic                 sys_clk,
   input  logic                 rst,
   input  logic                 load,
   input  logic [CNT_W-1:0]     width,
   input  logic [MAX_WIDTH-1:0] data,
   output logic                 spi_clk,
   output logic                 spi_data,
   output logic                 active,
   output logic                 bit_done,
   output logic                 last_bit
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [MAX_WIDTH-1:0] sreg_q, sreg_d;
   logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
   logic [DIV_W-1:0]     div_cnt_q, div_cnt_d;
   logic                 high_q, high_d;
   logic                 active_q, active_d;
   logic                 half_end;

   assign half_end = (div_cnt_q == DIV_W'(CLK_DIV - 1));

   // NOTE: every _d signal gets its default first so no path can infer a latch.
   always_comb begin
      sreg_d    = sreg_q;
      bit_cnt_d = bit_cnt_q;
      div_cnt_d = div_cnt_q;
      high_d    = high_q;
      active_d  = active_q;
      if (active_q) begin
         if (half_end) begin
            div_cnt_d = '0;
            if (!high_q) begin
               high_d = 1'b1;
            end else begin
               high_d = 1'b0;
               if (bit_cnt_q == '0) begin
                  active_d = 1'b0;
               end else begin
                  bit_cnt_d = bit_cnt_q - CNT_W'(1);
                  sreg_d    = sreg_q << 1;
               end
            end
         end else begin
            div_cnt_d = div_cnt_q + DIV_W'(1);
         end
      end else if (load) begin
         sreg_d    = data;
         bit_cnt_d = width - CNT_W'(1);
         div_cnt_d = '0;
         high_d    = 1'b0;
         active_d  = (width != '0);
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         sreg_q    <= '0;
         bit_cnt_q <= '0;
         div_cnt_q <= '0;
         high_q    <= 1'b0;
         active_q  <= 1'b0;
      end else begin
         sreg_q    <= sreg_d;
         bit_cnt_q <= bit_cnt_d;
         div_cnt_q <= div_cnt_d;
         high_q    <= high_d;
         active_q  <= active_d;
      end
   end

   assign spi_clk  = active_q & high_q;
   assign spi_data = active_q & sreg_q[MAX_WIDTH-1];
   assign active   = active_q;
   assign bit_done = active_q & high_q & half_end;
   assign last_bit = active_q & (bit_cnt_q == '0);

endmodule

// File: rtl/dds_sweep_ctrl.sv
// dds_sweep_ctrl
// Frequency sweep controller for a serially loaded dds. A sweep loads the phase
// word once, then loads start_word, start_word+step_word, ... up to and
// including stop_word, holding each frequency for dwell cycles.
// Ports:
//   sys_clk, rst           clock, asynchronous active-high reset
//   start, abort           one-cycle request pulses
//   start_word, stop_word, step_word, phase_word, dwell   sweep setup, captured on start
//   spi_clk, spi_data      serial bus to the dds, MSB first
//   freq_cs, phaseshift_cs chip selects; the falling edge loads the dds
//   cur_word               frequency word most recently loaded
//   busy, done             status: not idle / one-cycle end-of-sweep pulse
module dds_sweep_ctrl
   import dds_pkg::*;
#(
   parameter int FREQ_WIDTH  = DDS_FREQ_WIDTH,
   parameter int PHASE_WIDTH = DDS_PHASE_WIDTH,
   parameter int CLK_DIV     = 2,
   parameter int DWELL_WIDTH = 24
) (
   input  logic                   sys_clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   abort,
   input  logic [FREQ_WIDTH-1:0]  start_word,
   input  logic [FREQ_WIDTH-1:0]  stop_word,
   input  logic [FREQ_WIDTH-1:0]  step_word,
   input  logic [PHASE_WIDTH-1:0] phase_word,
   input  logic [DWELL_WIDTH-1:0] dwell,
   output logic                   spi_clk,
   output logic                   spi_data,
   output logic                   freq_cs,
   output logic                   phaseshift_cs,
   output logic [FREQ_WIDTH-1:0]  cur_word,
   output logic                   busy,
   output logic                   done
);

   localparam int SHIFT_W = (FREQ_WIDTH > PHASE_WIDTH) ? FREQ_WIDTH : PHASE_WIDTH;
   localparam int CNT_W   = $clog2(SHIFT_W + 1);
   localparam int LAT_W   = $clog2(2 * CLK_DIV + 1);

   state_e                 state_q, state_d;
   logic [FREQ_WIDTH-1:0]  stop_q, stop_d, step_q, step_d;
   logic [FREQ_WIDTH-1:0]  freq_q, freq_d, cur_word_q, cur_word_d;
   logic [DWELL_WIDTH-1:0] dwell_q, dwell_d, dwell_cnt_q, dwell_cnt_d;
   logic [LAT_W-1:0]       lat_cnt_q, lat_cnt_d;
   logic                   abort_q, abort_d, from_phase_q, from_phase_d;

   logic                   sh_load, sh_active, sh_bit_done, sh_last_bit;
   logic [CNT_W-1:0]       sh_width;
   logic [SHIFT_W-1:0]     sh_data;
   logic                   word_end, advance, sweep_end;
   logic [FREQ_WIDTH:0]    next_sum;

   // One extra bit so a wrap past all-ones shows up as a carry, not a small word.
   assign next_sum  = {1'b0, cur_word_q} + {1'b0, step_q};
   assign sweep_end = next_sum[FREQ_WIDTH] || (next_sum[FREQ_WIDTH-1:0] > stop_q) ||
                      (step_q == '0);
   assign word_end  = sh_bit_done & sh_last_bit;

   always_comb begin
      state_d      = state_q;
      stop_d       = stop_q;
      step_d       = step_q;
      freq_d       = freq_q;
      cur_word_d   = cur_word_q;
      dwell_d      = dwell_q;
      dwell_cnt_d  = dwell_cnt_q;
      lat_cnt_d    = lat_cnt_q;
      abort_d      = abort_q;
      from_phase_d = from_phase_q;
      advance      = 1'b0;
      sh_load      = 1'b0;
      sh_width     = CNT_W'(FREQ_WIDTH);
      sh_data      = SHIFT_W'(freq_q) << (SHIFT_W - FREQ_WIDTH);

      case (state_q)
         ST_IDLE: begin
            // abort is ignored here, even when it arrives together with start.
            if (start) begin
               stop_d   = stop_word;
               step_d   = step_word;
               dwell_d  = dwell;
               freq_d   = start_word;
               abort_d  = 1'b0;
               sh_load  = 1'b1;
               sh_width = CNT_W'(PHASE_WIDTH);
               sh_data  = SHIFT_W'(phase_word) << (SHIFT_W - PHASE_WIDTH);
               state_d  = ST_SHIFT_PHASE;
            end
         end
         ST_SHIFT_PHASE, ST_SHIFT_FREQ: begin
            // An abort is only remembered here so the word in flight completes.
            if (abort) abort_d = 1'b1;
            if (word_end) begin
               lat_cnt_d    = LAT_W'(2 * CLK_DIV - 1);
               from_phase_d = (state_q == ST_SHIFT_PHASE);
               if (state_q == ST_SHIFT_FREQ) cur_word_d = freq_q;
               state_d = ST_LATCH;
            end
         end
         ST_LATCH: begin
            if (abort) begin
               state_d = ST_FINISH;
            end else if (lat_cnt_q != '0) begin
               lat_cnt_d = lat_cnt_q - LAT_W'(1);
            end else if (abort_q) begin
               state_d = ST_FINISH;
            end else if (from_phase_q) begin
               sh_load = 1'b1;
               state_d = ST_SHIFT_FREQ;
            end else if (dwell_q != '0) begin
               dwell_cnt_d = dwell_q - DWELL_WIDTH'(1);
               state_d     = ST_DWELL;
            end else begin
               advance = 1'b1;
            end
         end
         ST_DWELL: begin
            if (abort) begin
               state_d = ST_FINISH;
            end else if (dwell_cnt_q != '0) begin
               dwell_cnt_d = dwell_cnt_q - DWELL_WIDTH'(1);
            end else begin
               advance = 1'b1;
            end
         end
         ST_FINISH: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase

      if (advance) begin
         if (sweep_end) begin
            state_d = ST_FINISH;
         end else begin
            freq_d  = next_sum[FREQ_WIDTH-1:0];
            sh_load = 1'b1;
            sh_data = SHIFT_W'(next_sum[FREQ_WIDTH-1:0]) << (SHIFT_W - FREQ_WIDTH);
            state_d = ST_SHIFT_FREQ;
         end
      end
   end

   // NOTE: the captured sweep setup is ordinary flops, so it is reset with the rest.
   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         stop_q       <= '0;
         step_q       <= '0;
         freq_q       <= '0;
         cur_word_q   <= '0;
         dwell_q      <= '0;
         dwell_cnt_q  <= '0;
         lat_cnt_q    <= '0;
         abort_q      <= 1'b0;
         from_phase_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         stop_q       <= stop_d;
         step_q       <= step_d;
         freq_q       <= freq_d;
         cur_word_q   <= cur_word_d;
         dwell_q      <= dwell_d;
         dwell_cnt_q  <= dwell_cnt_d;
         lat_cnt_q    <= lat_cnt_d;
         abort_q      <= abort_d;
         from_phase_q <= from_phase_d;
      end
   end

   dds_spi_shifter #(
      .MAX_WIDTH (SHIFT_W),
      .CLK_DIV   (CLK_DIV),
      .CNT_W     (CNT_W)
   ) u_shifter (
      .sys_clk  (sys_clk),
      .rst      (rst),
      .load     (sh_load),
      .width    (sh_width),
      .data     (sh_data),
      .spi_clk  (spi_clk),
      .spi_data (spi_data),
      .active   (sh_active),
      .bit_done (sh_bit_done),
      .last_bit (sh_last_bit)
   );

   // The shifter is only ever active in a shift state, so the state picks the select.
   assign freq_cs       = sh_active && (state_q == ST_SHIFT_FREQ);
   assign phaseshift_cs = sh_active && (state_q == ST_SHIFT_PHASE);
   assign cur_word      = cur_word_q;
   assign busy          = (state_q != ST_IDLE);
   assign done          = (state_q == ST_FINISH);

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// tb_dds_sweep_ctrl
// Self-checking bench for dds_sweep_ctrl with CLK_DIV=1. A model of the dds
// shift registers rebuilds every loaded word from spi_clk/spi_data; the
// expected load sequence comes from the sweep rules in plain arithmetic.
module tb_dds_sweep_ctrl;

   localparam int FW = 48;
   localparam int PW = 16;
   localparam int CD = 1;
   localparam int DW = 24;

   logic          sys_clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic [FW-1:0] start_word = '0, stop_word = '0, step_word = '0;
   logic [PW-1:0] phase_word = '0;
   logic [DW-1:0] dwell = '0;
   logic          spi_clk, spi_data, freq_cs, phaseshift_cs, busy, done;
   logic [FW-1:0] cur_word;

   always #5 sys_clk = ~sys_clk;

   dds_sweep_ctrl #(
      .FREQ_WIDTH (FW), .PHASE_WIDTH (PW), .CLK_DIV (CD), .DWELL_WIDTH (DW)
   ) dut (
      .sys_clk (sys_clk), .rst (rst), .start (start), .abort (abort),
      .start_word (start_word), .stop_word (stop_word), .step_word (step_word),
      .phase_word (phase_word), .dwell (dwell),
      .spi_clk (spi_clk), .spi_data (spi_data), .freq_cs (freq_cs),
      .phaseshift_cs (phaseshift_cs), .cur_word (cur_word), .busy (busy), .done (done)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // ---------------- dds model: shift registers latched on cs falling edge
   logic [FW-1:0] f_sr = '0;
   logic [PW-1:0] p_sr = '0;
   int            f_bits = 0, p_bits = 0, f_len = 0, p_len = 0;
   logic          prev_sclk = 1'b0, prev_fcs = 1'b0, prev_pcs = 1'b0;
   logic [FW-1:0] f_loads[$];
   logic [FW-1:0] cur_at_fall[$];
   int            f_lens[$], f_bitq[$];
   logic [PW-1:0] p_loads[$];
   int            p_lens[$], p_bitq[$];
   int            done_cnt = 0;
   int            cs_cycles = 0;

   always @(negedge sys_clk) begin
      if (rst) begin
         prev_sclk = 1'b0; prev_fcs = 1'b0; prev_pcs = 1'b0;
         f_bits = 0; p_bits = 0; f_len = 0; p_len = 0;
      end else begin
         if (freq_cs && !prev_fcs) begin f_sr = '0; f_bits = 0; f_len = 0; end
         if (phaseshift_cs && !prev_pcs) begin p_sr = '0; p_bits = 0; p_len = 0; end
         if (freq_cs) f_len++;
         if (phaseshift_cs) p_len++;
         if (freq_cs || phaseshift_cs) cs_cycles++;
         if (spi_clk && !prev_sclk) begin
            if (freq_cs) begin f_sr = {f_sr[FW-2:0], spi_data}; f_bits++; end
            if (phaseshift_cs) begin p_sr = {p_sr[PW-2:0], spi_data}; p_bits++; end
         end
         if (!freq_cs && prev_fcs) begin
            f_loads.push_back(f_sr); f_lens.push_back(f_len); f_bitq.push_back(f_bits);
            cur_at_fall.push_back(cur_word);
         end
         if (!phaseshift_cs && prev_pcs) begin
            p_loads.push_back(p_sr); p_lens.push_back(p_len); p_bitq.push_back(p_bits);
         end
         if (done) done_cnt++;
         prev_sclk = spi_clk; prev_fcs = freq_cs; prev_pcs = phaseshift_cs;
      end
   end

   // ---------------- reference: the words a sweep is expected to load
   logic [FW-1:0] exp_q[$];

   task automatic model_sweep(input logic [FW-1:0] s, input logic [FW-1:0] stop,
                              input logic [FW-1:0] step);
      longint unsigned w, n;
      exp_q.delete();
      w = 64'(s);
      for (int k = 0; k < 64; k++) begin
         exp_q.push_back(w[FW-1:0]);
         n = w + 64'(step);
         // stop is below 2**FW, so n > stop also covers running off the top.
         if (step == '0 || n > 64'(stop)) break;
         w = n;
      end
   endtask

   task automatic tick();
      @(negedge sys_clk);
      #1;
   endtask

   task automatic setup(input logic [FW-1:0] s, input logic [FW-1:0] stop,
                        input logic [FW-1:0] step, input logic [PW-1:0] ph,
                        input logic [DW-1:0] dw);
      start_word = s; stop_word = stop; step_word = step; phase_word = ph; dwell = dw;
   endtask

   // Pulse start, then scramble the inputs: the sweep must use the captured copies.
   task automatic pulse_start(input logic with_abort);
      start = 1'b1; abort = with_abort;
      tick();
      start = 1'b0; abort = 1'b0;
      start_word = FW'({$urandom(), $urandom()});
      stop_word  = FW'({$urandom(), $urandom()});
      step_word  = FW'($urandom());
      phase_word = PW'($urandom());
      dwell      = DW'($urandom_range(0, 3));
      check("busy_after_start", 64'(busy), 64'd1);
   endtask

   task automatic pulse_abort();
      abort = 1'b1;
      tick();
      abort = 1'b0;
   endtask

   task automatic wait_done(input int db, input int budget);
      int n = 0;
      while (done_cnt == db && n < budget) begin tick(); n++; end
      check("done_before_timeout", 64'(n < budget), 64'd1);
   endtask

   task automatic verify(input string tag, input int fb, input int pb, input int db,
                         input logic [PW-1:0] ph);
      int nf;
      check({tag, "_done_pulses"}, 64'(done_cnt - db), 64'd1);
      check({tag, "_busy_idle"}, 64'(busy), 64'd0);
      check({tag, "_phase_loads"}, 64'(p_loads.size() - pb), 64'd1);
      if (p_loads.size() > pb) begin
         check({tag, "_phase_word"}, 64'(p_loads[pb]), 64'(ph));
         check({tag, "_phase_bits"}, 64'(p_bitq[pb]), 64'(PW));
         check({tag, "_phase_cs_len"}, 64'(p_lens[pb]), 64'(2 * CD * PW));
      end
      check({tag, "_freq_loads"}, 64'(f_loads.size() - fb), 64'(exp_q.size()));
      nf = f_loads.size() - fb;
      if (nf > exp_q.size()) nf = exp_q.size();
      for (int i = 0; i < nf; i++) begin
         check($sformatf("%s_freq_word%0d", tag, i), 64'(f_loads[fb+i]), 64'(exp_q[i]));
         check($sformatf("%s_freq_bits%0d", tag, i), 64'(f_bitq[fb+i]), 64'(FW));
         check($sformatf("%s_freq_cs_len%0d", tag, i), 64'(f_lens[fb+i]), 64'(2 * CD * FW));
         check($sformatf("%s_cur_at_fall%0d", tag, i), 64'(cur_at_fall[fb+i]), 64'(exp_q[i]));
      end
      check({tag, "_cur_word_final"}, 64'(cur_word), 64'(exp_q[exp_q.size()-1]));
   endtask

   task automatic run_sweep(input string tag, input logic [FW-1:0] s,
                            input logic [FW-1:0] stop, input logic [FW-1:0] step,
                            input logic [PW-1:0] ph, input logic [DW-1:0] dw,
                            input logic with_abort);
      int fb = f_loads.size();
      int pb = p_loads.size();
      int db = done_cnt;
      model_sweep(s, stop, step);
      setup(s, stop, step, ph, dw);
      pulse_start(with_abort);
      wait_done(db, 20000);
      repeat (3) tick();
      verify(tag, fb, pb, db, ph);
   endtask

   initial begin
      int fb, pb, db, n, cs0;
      longint unsigned s, st, nw;

      // ---- reset state
      repeat (3) tick();
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_cs", 64'({freq_cs, phaseshift_cs, spi_clk, spi_data}), 64'd0);
      check("rst_cur_word", 64'(cur_word), 64'd0);
      rst = 1'b0;
      tick();

      // ---- abort alone in IDLE is ignored
      pulse_abort();
      tick();
      check("idle_abort_busy", 64'(busy), 64'd0);

      // ---- directed sweeps
      run_sweep("sweep", 48'd100, 48'd130, 48'd10, 16'h4000, 24'd5, 1'b0);
      run_sweep("single", 48'd500, 48'd500, 48'd0, 16'h1234, 24'd3, 1'b0);
      run_sweep("overflow", 48'hFFFF_FFFF_FFF0, 48'hFFFF_FFFF_FFFF, 48'd32,
                16'hA5C3, 24'd2, 1'b0);
      run_sweep("start_gt_stop", 48'd900, 48'd800, 48'd5, 16'h0F0F, 24'd0, 1'b0);
      run_sweep("start_with_abort", 48'd40, 48'd70, 48'd15, 16'h8001, 24'd1, 1'b1);

      // ---- abort mid-shift, at bit 20 of the second freq word
      fb = f_loads.size(); pb = p_loads.size(); db = done_cnt;
      model_sweep(48'd1000, 48'd100000, 48'd7);
      while (exp_q.size() > 2) void'(exp_q.pop_back());
      setup(48'd1000, 48'd100000, 48'd7, 16'h2222, 24'd2);
      pulse_start(1'b0);
      n = 0;
      while (!(f_loads.size() == fb + 1 && freq_cs && f_bits == 20) && n < 5000) begin
         tick(); n++;
      end
      check("abort_shift_reached_bit20", 64'(n < 5000), 64'd1);
      pulse_abort();
      wait_done(db, 2000);
      repeat (3) tick();
      verify("abort_shift", fb, pb, db, 16'h2222);

      // ---- abort during a long dwell
      fb = f_loads.size(); pb = p_loads.size(); db = done_cnt;
      model_sweep(48'd2000, 48'd90000, 48'd500);
      while (exp_q.size() > 1) void'(exp_q.pop_back());
      setup(48'd2000, 48'd90000, 48'd500, 16'h3C3C, 24'd1000);
      pulse_start(1'b0);
      n = 0;
      while (f_loads.size() == fb && n < 5000) begin tick(); n++; end
      check("abort_dwell_first_load", 64'(n < 5000), 64'd1);
      repeat (12) tick();
      pulse_abort();
      n = 0;
      while (done_cnt == db && n < 1) begin tick(); n++; end
      check("abort_dwell_done_latency", 64'(done_cnt - db), 64'd1);
      cs0 = cs_cycles;
      repeat (50) tick();
      check("abort_dwell_no_cs", 64'(cs_cycles - cs0), 64'd0);
      verify("abort_dwell", fb, pb, db, 16'h3C3C);

      // ---- reset at bit 5 of the second freq word
      fb = f_loads.size(); db = done_cnt;
      setup(48'd3000, 48'd90000, 48'd11, 16'h5555, 24'd4);
      pulse_start(1'b0);
      n = 0;
      while (!(f_loads.size() == fb + 1 && freq_cs && f_bits == 5) && n < 5000) begin
         tick(); n++;
      end
      check("rst_shift_reached_bit5", 64'(n < 5000), 64'd1);
      check("rst_shift_cur_before", 64'(cur_word), 64'd3000);
      #2 rst = 1'b1;
      #1;
      check("rst_shift_outputs", 64'({spi_clk, spi_data, freq_cs, phaseshift_cs}), 64'd0);
      check("rst_shift_busy", 64'(busy), 64'd0);
      check("rst_shift_done", 64'(done), 64'd0);
      check("rst_shift_cur_word", 64'(cur_word), 64'd0);
      repeat (2) tick();
      rst = 1'b0;
      repeat (5) tick();
      check("rst_shift_idle", 64'(busy), 64'd0);
      check("rst_shift_no_done", 64'(done_cnt - db), 64'd0);
      check("rst_shift_no_load", 64'(f_loads.size() - fb), 64'd1);

      // ---- randomized sweeps
      for (int r = 0; r < 6; r++) begin
         s  = longint'($urandom_range(1, 5000));
         st = longint'($urandom_range(1, 300));
         nw = longint'($urandom_range(1, 5));
         if (r == 4) run_sweep($sformatf("rand%0d", r), FW'(s), FW'(s + 100), '0,
                               PW'($urandom()), DW'($urandom_range(0, 6)), 1'b0);
         else if (r == 5) run_sweep($sformatf("rand%0d", r), FW'(s), FW'(s - 1), FW'(st),
                                    PW'($urandom()), DW'($urandom_range(0, 6)), 1'b0);
         else run_sweep($sformatf("rand%0d", r), FW'(s),
                        FW'(s + st * (nw - 1) + longint'($urandom_range(0, 32'(st) - 1))),
                        FW'(st), PW'($urandom()), DW'($urandom_range(0, 6)), 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #900_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

endmodule
